// File: rtl/arb_engine.sv
// arb_engine: sequencer for the arbitrage-detection datapath.
// Buffers edge updates in a FIFO, writes them into the adjacency matrix, then runs one
// Bellman-Ford pass followed by one cycle-detect pass on request, steering the memory mux.
// Optional feature macro: REVERSE_EDGE_EN (also write the negated reverse edge per update).
module arb_engine #(
    parameter int N_VERT    = 32,
    parameter int WEIGHT_W  = 32,
    parameter int UPD_DEPTH = 8,
    parameter int AUTO_RUN  = 0,
    localparam int VID_W    = $clog2(N_VERT)
) (
    input  logic                clk,
    input  logic                engine_reset,
    input  logic                upd_valid,
    output logic                upd_ready,
    input  logic [VID_W-1:0]    upd_src,
    input  logic [VID_W-1:0]    upd_dst,
    input  logic [WEIGHT_W-1:0] upd_weight,
    input  logic                run_req,
    output logic                adj_we,
    output logic [VID_W-1:0]    adj_row,
    output logic [VID_W-1:0]    adj_col,
    output logic [WEIGHT_W-1:0] adj_data,
    output logic [1:0]          mem_sel,
    output logic                bellman_start,
    input  logic                bellman_done,
    output logic                cycle_start,
    input  logic                cycle_done,
    input  logic                cycle_found,
    output logic                busy,
    output logic                result_valid,
    output logic                result_cycle,
    output logic [15:0]         pass_count,
    output logic                err_self_loop
);

    localparam int PTR_W   = $clog2(UPD_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = 2 * VID_W + WEIGHT_W;

    localparam logic [CNT_W-1:0]    FULL_CNT = CNT_W'(UPD_DEPTH);
    localparam logic [WEIGHT_W-1:0] W_MIN    = {1'b1, {(WEIGHT_W-1){1'b0}}};
    localparam logic [WEIGHT_W-1:0] W_MAX    = {1'b0, {(WEIGHT_W-1){1'b1}}};

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_DRAIN_FWD = 3'd1;
    localparam logic [2:0] ST_DRAIN_REV = 3'd2;
    localparam logic [2:0] ST_START_BF  = 3'd3;
    localparam logic [2:0] ST_WAIT_BF   = 3'd4;
    localparam logic [2:0] ST_START_CD  = 3'd5;
    localparam logic [2:0] ST_WAIT_CD   = 3'd6;
    localparam logic [2:0] ST_REPORT    = 3'd7;

    logic [2:0]          state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [ENTRY_W-1:0]  fifo_mem [UPD_DEPTH];
    logic                pending_q, pending_d;
    logic                ready_en_q;
    logic                err_q;
    logic                set_err;
    logic                result_cycle_q;
    logic [15:0]         pass_count_q;

    logic                push, pop;
    logic                remaining;
    logic [VID_W-1:0]    head_src, head_dst;
    logic [WEIGHT_W-1:0] head_w, neg_w;
    logic                self_loop;

    // ready stays low through reset and rises on the first clock after release
    assign upd_ready = ready_en_q && (count_q != FULL_CNT);
    assign push      = upd_valid && upd_ready;

    assign {head_src, head_dst, head_w} = fifo_mem[rd_ptr_q];
    assign self_loop = (head_src == head_dst);
    // Saturate: the most negative weight has no positive counterpart
    assign neg_w     = (head_w == W_MIN) ? W_MAX : -head_w;

    // Entries left after the pop in the current cycle (only meaningful while popping)
    assign remaining = (count_q != CNT_W'(1)) || push;

    // Next-state, pop and pending-request logic
    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        set_err   = 1'b0;
        pending_d = pending_q | run_req;
        case (state_q)
            ST_IDLE: begin
                // Queued updates always go ahead of a pass
                if (count_q != '0 || push) begin
                    state_d = ST_DRAIN_FWD;
                end else if (pending_q || run_req) begin
                    state_d   = ST_START_BF;
                    pending_d = 1'b0;
                end
            end
            ST_DRAIN_FWD: begin
                if (self_loop) begin
                    set_err = 1'b1;
                    pop     = 1'b1;
                end else begin
`ifdef REVERSE_EDGE_EN
                    state_d = ST_DRAIN_REV;
`else
                    pop     = 1'b1;
`endif
                end
                if (pop) begin
                    if (remaining) begin
                        state_d = ST_DRAIN_FWD;
                    end else begin
                        state_d = ST_IDLE;
                        if (AUTO_RUN != 0) pending_d = 1'b1;
                    end
                end
            end
            ST_DRAIN_REV: begin
                pop = 1'b1;
                if (remaining) begin
                    state_d = ST_DRAIN_FWD;
                end else begin
                    state_d = ST_IDLE;
                    if (AUTO_RUN != 0) pending_d = 1'b1;
                end
            end
            ST_START_BF: state_d = ST_WAIT_BF;
            ST_WAIT_BF:  if (bellman_done) state_d = ST_START_CD;
            ST_START_CD: state_d = ST_WAIT_CD;
            ST_WAIT_CD:  if (cycle_done) state_d = ST_REPORT;
            ST_REPORT:   state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // FIFO occupancy: simultaneous push and pop leave the count unchanged
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Adjacency write port, zeroed whenever no write is issued
    always_comb begin
        adj_we   = 1'b0;
        adj_row  = '0;
        adj_col  = '0;
        adj_data = '0;
        case (state_q)
            ST_DRAIN_FWD: begin
                if (!self_loop) begin
                    adj_we   = 1'b1;
                    adj_row  = head_src;
                    adj_col  = head_dst;
                    adj_data = head_w;
                end
            end
            ST_DRAIN_REV: begin
                adj_we   = 1'b1;
                adj_row  = head_dst;
                adj_col  = head_src;
                adj_data = neg_w;
            end
            default: ;
        endcase
    end

    // Pass control outputs decoded from state
    always_comb begin
        bellman_start = (state_q == ST_START_BF);
        cycle_start   = (state_q == ST_START_CD);
        result_valid  = (state_q == ST_REPORT);
        if (state_q == ST_START_BF || state_q == ST_WAIT_BF) begin
            mem_sel = 2'd1;
        end else if (state_q == ST_START_CD || state_q == ST_WAIT_CD) begin
            mem_sel = 2'd2;
        end else begin
            mem_sel = 2'd0;
        end
    end

    assign busy          = (state_q != ST_IDLE) || (count_q != '0);
    assign result_cycle  = result_cycle_q;
    assign pass_count    = pass_count_q;
    assign err_self_loop = err_q;

    // FIFO storage; contents are don't-care until pushed, so no reset
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= {upd_src, upd_dst, upd_weight};
    end

    // Control state, FIFO pointers and status registers
    always_ff @(posedge clk or posedge engine_reset) begin
        if (engine_reset) begin
            state_q        <= ST_IDLE;
            count_q        <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            pending_q      <= 1'b0;
            ready_en_q     <= 1'b0;
            err_q          <= 1'b0;
            result_cycle_q <= 1'b0;
            pass_count_q   <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            pending_q  <= pending_d;
            ready_en_q <= 1'b1;
            if (push)    wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (set_err) err_q    <= 1'b1;
            // Latched at cycle_done so it is already valid alongside result_valid
            if (state_q == ST_WAIT_CD && cycle_done) result_cycle_q <= cycle_found;
            if (state_q == ST_REPORT) pass_count_q <= pass_count_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_arb_engine.sv
// Directed bench for arb_engine; expectations follow REVERSE_EDGE_EN when it is defined.
`timescale 1ns/1ps
module tb_arb_engine;

    localparam int N_VERT    = 32;
    localparam int WEIGHT_W  = 32;
    localparam int UPD_DEPTH = 8;
    localparam int VID_W     = 5;

    logic                clk = 1'b0;
    logic                engine_reset;
    logic                upd_valid;
    logic                upd_ready;
    logic [VID_W-1:0]    upd_src, upd_dst;
    logic [WEIGHT_W-1:0] upd_weight;
    logic                run_req;
    logic                adj_we;
    logic [VID_W-1:0]    adj_row, adj_col;
    logic [WEIGHT_W-1:0] adj_data;
    logic [1:0]          mem_sel;
    logic                bellman_start, bellman_done;
    logic                cycle_start, cycle_done, cycle_found;
    logic                busy, result_valid, result_cycle;
    logic [15:0]         pass_count;
    logic                err_self_loop;

    always #5 clk = ~clk;

    arb_engine #(
        .N_VERT    (N_VERT),
        .WEIGHT_W  (WEIGHT_W),
        .UPD_DEPTH (UPD_DEPTH),
        .AUTO_RUN  (0)
    ) dut (
        .clk           (clk),
        .engine_reset  (engine_reset),
        .upd_valid     (upd_valid),
        .upd_ready     (upd_ready),
        .upd_src       (upd_src),
        .upd_dst       (upd_dst),
        .upd_weight    (upd_weight),
        .run_req       (run_req),
        .adj_we        (adj_we),
        .adj_row       (adj_row),
        .adj_col       (adj_col),
        .adj_data      (adj_data),
        .mem_sel       (mem_sel),
        .bellman_start (bellman_start),
        .bellman_done  (bellman_done),
        .cycle_start   (cycle_start),
        .cycle_done    (cycle_done),
        .cycle_found   (cycle_found),
        .busy          (busy),
        .result_valid  (result_valid),
        .result_cycle  (result_cycle),
        .pass_count    (pass_count),
        .err_self_loop (err_self_loop)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int rv_count = 0;
    logic [41:0] wr_log [$];
    logic [42:0] adj_vec;

    assign adj_vec = {adj_we, adj_row, adj_col, adj_data};

    // Log every adjacency write and result pulse, sampled mid-cycle
    always @(negedge clk) begin
        if (adj_we) wr_log.push_back({adj_row, adj_col, adj_data});
        if (result_valid) rv_count++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [67:0] outs;
        engine_reset = 1'b1;
        upd_valid    = 1'b1;
        upd_src      = 5'd1;
        upd_dst      = 5'd2;
        upd_weight   = 32'h0000_0011;
        run_req      = 1'b0;
        bellman_done = 1'b0;
        cycle_done   = 1'b0;
        cycle_found  = 1'b0;
        tick();
        tick();
        outs = {upd_ready, adj_vec, mem_sel, bellman_start, cycle_start, busy, result_valid,
                result_cycle, pass_count, err_self_loop};
        n_checks++;
        if (outs !== 68'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected %h", outs, 68'h0);
        end
        engine_reset = 1'b0;
        #1;
        n_checks++;
        if (upd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_before_clk: got %b expected 0", upd_ready);
        end
        tick();
        upd_valid = 1'b0;
        n_checks++;
        if ({upd_ready, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL ready_after_release: got ready,busy=%b expected 10", {upd_ready, busy});
        end
    endtask

    task automatic test_basic_write();
        upd_valid  = 1'b1;
        upd_src    = 5'd2;
        upd_dst    = 5'd5;
        upd_weight = 32'h0000_0100;
        tick();
        upd_valid = 1'b0;
        n_checks++;
        if (adj_vec !== {1'b1, 5'd2, 5'd5, 32'h0000_0100}) begin
            n_fail++;
            $display("FAIL basic_fwd: got %h expected %h", adj_vec,
                     {1'b1, 5'd2, 5'd5, 32'h0000_0100});
        end
        tick();
`ifdef REVERSE_EDGE_EN
        n_checks++;
        if (adj_vec !== {1'b1, 5'd5, 5'd2, 32'hFFFF_FF00}) begin
            n_fail++;
            $display("FAIL basic_rev: got %h expected %h", adj_vec,
                     {1'b1, 5'd5, 5'd2, 32'hFFFF_FF00});
        end
        tick();
`endif
        n_checks++;
        if ({busy, adj_we} !== 2'b00) begin
            n_fail++;
            $display("FAIL basic_idle: got busy,we=%b expected 00", {busy, adj_we});
        end
    endtask

    task automatic test_negation();
        logic [4:0]  s [4];
        logic [4:0]  d [4];
        logic [31:0] w [4];
        logic [31:0] nw [4];
        s[0] = 5'd1;  d[0] = 5'd4;  w[0] = 32'h8000_0000; nw[0] = 32'h7FFF_FFFF;
        s[1] = 5'd7;  d[1] = 5'd0;  w[1] = 32'hFFFF_FFFF; nw[1] = 32'h0000_0001;
        s[2] = 5'd31; d[2] = 5'd30; w[2] = 32'h7FFF_FFFF; nw[2] = 32'h8000_0001;
        s[3] = 5'd12; d[3] = 5'd13; w[3] = 32'h0000_0000; nw[3] = 32'h0000_0000;
        for (int i = 0; i < 4; i++) begin
            upd_valid  = 1'b1;
            upd_src    = s[i];
            upd_dst    = d[i];
            upd_weight = w[i];
            tick();
            upd_valid = 1'b0;
            n_checks++;
            if (adj_vec !== {1'b1, s[i], d[i], w[i]}) begin
                n_fail++;
                $display("FAIL neg_fwd[%0d]: got %h expected %h", i, adj_vec,
                         {1'b1, s[i], d[i], w[i]});
            end
            tick();
`ifdef REVERSE_EDGE_EN
            n_checks++;
            if (adj_vec !== {1'b1, d[i], s[i], nw[i]}) begin
                n_fail++;
                $display("FAIL neg_rev[%0d]: got %h expected %h", i, adj_vec,
                         {1'b1, d[i], s[i], nw[i]});
            end
            tick();
`endif
            n_checks++;
            if (busy !== 1'b0) begin
                n_fail++;
                $display("FAIL neg_idle[%0d]: got busy=%b expected 0", i, busy);
            end
        end
    endtask

    task automatic test_self_loop();
        int base;
        base       = wr_log.size();
        upd_valid  = 1'b1;
        upd_src    = 5'd3;
        upd_dst    = 5'd3;
        upd_weight = 32'h0000_0055;
        tick();
        upd_valid = 1'b0;
        n_checks++;
        if ({busy, adj_vec} !== {1'b1, 43'h0}) begin
            n_fail++;
            $display("FAIL self_loop_nowrite: got %h expected %h", {busy, adj_vec},
                     {1'b1, 43'h0});
        end
        tick();
        tick();
        n_checks++;
        if ({err_self_loop, busy} !== 2'b10 || wr_log.size() != base) begin
            n_fail++;
            $display("FAIL self_loop_err: got err,busy=%b writes=%0d expected 10 writes=0",
                     {err_self_loop, busy}, wr_log.size() - base);
        end
    endtask

    task automatic test_pass();
        int rv0;
        rv0 = rv_count;
        bellman_done = 1'b1;
        tick();
        bellman_done = 1'b0;
        n_checks++;
        if ({busy, mem_sel, cycle_start} !== 4'b0) begin
            n_fail++;
            $display("FAIL bf_done_ignored_idle: got %b expected 0000",
                     {busy, mem_sel, cycle_start});
        end
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        n_checks++;
        if ({bellman_start, cycle_start, mem_sel} !== 4'b1001) begin
            n_fail++;
            $display("FAIL start_bf: got %b expected 1001", {bellman_start, cycle_start, mem_sel});
        end
        tick();
        repeat (18) tick();
        n_checks++;
        if ({bellman_start, mem_sel} !== 3'b001) begin
            n_fail++;
            $display("FAIL wait_bf: got %b expected 001", {bellman_start, mem_sel});
        end
        bellman_done = 1'b1;
        tick();
        bellman_done = 1'b0;
        n_checks++;
        if ({cycle_start, mem_sel} !== 3'b110) begin
            n_fail++;
            $display("FAIL start_cd: got %b expected 110", {cycle_start, mem_sel});
        end
        tick();
        bellman_done = 1'b1;
        repeat (8) tick();
        bellman_done = 1'b0;
        n_checks++;
        if ({cycle_start, mem_sel, result_valid} !== 4'b0100) begin
            n_fail++;
            $display("FAIL wait_cd: got %b expected 0100", {cycle_start, mem_sel, result_valid});
        end
        cycle_done  = 1'b1;
        cycle_found = 1'b1;
        tick();
        cycle_done  = 1'b0;
        cycle_found = 1'b0;
        n_checks++;
        if ({result_valid, result_cycle, mem_sel} !== 4'b1100) begin
            n_fail++;
            $display("FAIL report: got %b expected 1100", {result_valid, result_cycle, mem_sel});
        end
        tick();
        n_checks++;
        if ({result_valid, result_cycle, busy, pass_count} !== {3'b010, 16'd1}) begin
            n_fail++;
            $display("FAIL pass_done: got %h expected %h",
                     {result_valid, result_cycle, busy, pass_count}, {3'b010, 16'd1});
        end
        n_checks++;
        if (rv_count - rv0 != 1) begin
            n_fail++;
            $display("FAIL result_pulses: got %0d expected 1", rv_count - rv0);
        end
    endtask

    task automatic test_req_during_pass();
        logic seen_start;
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        tick();
        run_req    = 1'b1;
        upd_valid  = 1'b1;
        upd_src    = 5'd6;
        upd_dst    = 5'd9;
        upd_weight = 32'h0000_0042;
        tick();
        run_req   = 1'b0;
        upd_valid = 1'b0;
        n_checks++;
        if ({adj_we, busy, mem_sel} !== 4'b0101) begin
            n_fail++;
            $display("FAIL no_write_in_pass: got %b expected 0101", {adj_we, busy, mem_sel});
        end
        repeat (3) tick();
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        repeat (5) tick();
        bellman_done = 1'b1;
        tick();
        bellman_done = 1'b0;
        tick();
        cycle_done = 1'b1;
        tick();
        cycle_done = 1'b0;
        n_checks++;
        if ({result_valid, result_cycle, adj_we} !== 3'b100) begin
            n_fail++;
            $display("FAIL report_no_cycle: got %b expected 100",
                     {result_valid, result_cycle, adj_we});
        end
        tick();
        n_checks++;
        if ({pass_count, adj_we, mem_sel} !== {16'd2, 3'b000}) begin
            n_fail++;
            $display("FAIL after_report: got %h expected %h", {pass_count, adj_we, mem_sel},
                     {16'd2, 3'b000});
        end
        tick();
        n_checks++;
        if (adj_vec !== {1'b1, 5'd6, 5'd9, 32'h0000_0042}) begin
            n_fail++;
            $display("FAIL deferred_fwd: got %h expected %h", adj_vec,
                     {1'b1, 5'd6, 5'd9, 32'h0000_0042});
        end
        tick();
`ifdef REVERSE_EDGE_EN
        n_checks++;
        if (adj_vec !== {1'b1, 5'd9, 5'd6, 32'hFFFF_FFBE}) begin
            n_fail++;
            $display("FAIL deferred_rev: got %h expected %h", adj_vec,
                     {1'b1, 5'd9, 5'd6, 32'hFFFF_FFBE});
        end
        tick();
`endif
        n_checks++;
        if ({adj_we, bellman_start, mem_sel} !== 4'b0) begin
            n_fail++;
            $display("FAIL idle_before_second: got %b expected 0000",
                     {adj_we, bellman_start, mem_sel});
        end
        tick();
        n_checks++;
        if ({bellman_start, mem_sel} !== 3'b101) begin
            n_fail++;
            $display("FAIL second_pass_start: got %b expected 101", {bellman_start, mem_sel});
        end
        tick();
        bellman_done = 1'b1;
        tick();
        bellman_done = 1'b0;
        tick();
        cycle_done  = 1'b1;
        cycle_found = 1'b1;
        tick();
        cycle_done  = 1'b0;
        cycle_found = 1'b0;
        tick();
        n_checks++;
        if ({pass_count, result_cycle} !== {16'd3, 1'b1}) begin
            n_fail++;
            $display("FAIL second_pass_done: got %h expected %h", {pass_count, result_cycle},
                     {16'd3, 1'b1});
        end
        seen_start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (bellman_start) seen_start = 1'b1;
            tick();
        end
        n_checks++;
        if ({seen_start, busy, err_self_loop} !== 3'b001) begin
            n_fail++;
            $display("FAIL merged_requests: got start,busy,err=%b expected 001",
                     {seen_start, busy, err_self_loop});
        end
    endtask

    task automatic test_full_fifo();
        int          base;
        int          per;
        logic        accepted;
        logic        went_idle;
        logic [4:0]  s, d;
        logic [31:0] w;
        logic [41:0] exp_e;
`ifdef REVERSE_EDGE_EN
        per = 2;
`else
        per = 1;
`endif
        engine_reset = 1'b1;
        tick();
        n_checks++;
        if ({err_self_loop, result_cycle, upd_ready, busy, pass_count} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_clears: got %h expected 0",
                     {err_self_loop, result_cycle, upd_ready, busy, pass_count});
        end
        engine_reset = 1'b0;
        tick();
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        tick();
        base = wr_log.size();
        for (int i = 0; i < 9; i++) begin
            s          = 5'(i);
            d          = 5'(i + 10);
            upd_valid  = 1'b1;
            upd_src    = s;
            upd_dst    = d;
            upd_weight = 32'h0000_1000 + 32'(i * 17);
            n_checks++;
            if (upd_ready !== (i < 8)) begin
                n_fail++;
                $display("FAIL fill_ready[%0d]: got %b expected %b", i, upd_ready, (i < 8));
            end
            if (i < 8) tick();
        end
        bellman_done = 1'b1;
        tick();
        bellman_done = 1'b0;
        tick();
        cycle_done = 1'b1;
        tick();
        cycle_done = 1'b0;
        n_checks++;
        if ({result_valid, upd_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL full_at_report: got valid,ready=%b expected 10",
                     {result_valid, upd_ready});
        end
        accepted = 1'b0;
        for (int k = 0; k < 50 && !accepted; k++) begin
            if (upd_ready) accepted = 1'b1;
            tick();
        end
        upd_valid = 1'b0;
        went_idle = 1'b0;
        for (int k = 0; k < 200 && !went_idle; k++) begin
            if (!busy) went_idle = 1'b1;
            else tick();
        end
        n_checks++;
        if ({accepted, went_idle} !== 2'b11) begin
            n_fail++;
            $display("FAIL drain_complete: got accepted,idle=%b expected 11",
                     {accepted, went_idle});
        end
        n_checks++;
        if (wr_log.size() - base != 9 * per) begin
            n_fail++;
            $display("FAIL drain_count: got %0d expected %0d", wr_log.size() - base, 9 * per);
        end else begin
            for (int i = 0; i < 9; i++) begin
                s     = 5'(i);
                d     = 5'(i + 10);
                w     = 32'h0000_1000 + 32'(i * 17);
                exp_e = {s, d, w};
                n_checks++;
                if (wr_log[base + i * per] !== exp_e) begin
                    n_fail++;
                    $display("FAIL drain_fwd[%0d]: got %h expected %h", i,
                             wr_log[base + i * per], exp_e);
                end
                if (per == 2) begin
                    exp_e = {d, s, -w};
                    n_checks++;
                    if (wr_log[base + i * per + 1] !== exp_e) begin
                        n_fail++;
                        $display("FAIL drain_rev[%0d]: got %h expected %h", i,
                                 wr_log[base + i * per + 1], exp_e);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_negation();
        test_self_loop();
        test_pass();
        test_req_during_pass();
        test_full_fifo();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/arb_engine.md
# arb_engine

Parametrised sequencer for the arbitrage-detection datapath. Accepts a stream of exchange-rate edge updates through a buffered valid/ready port and writes each update into the adjacency matrix: the forward edge, plus the negated reverse edge when enabled. On request it runs one Bellman-Ford pass, then one cycle-detect pass, by handshaking with those sub-blocks and steering the shared memory mux. It reports the cycle result and keeps pass statistics.

## Interface
- N_VERT, 32: vertex count; VID_W = $clog2(N_VERT).
- WEIGHT_W, 32: signed edge-weight width.
- UPD_DEPTH, 8: update FIFO depth (power of 2, ≥2).
- AUTO_RUN, 0: 1 = start a pass automatically after every non-empty drain.
- clk  in  1  clock.
- engine_reset  in  1  reset, asynchronous, active-high.
- upd_valid  in  1  update offered.
- upd_ready  out  1  FIFO can accept.
- upd_src, upd_dst  in  VID_W each  edge endpoints.
- upd_weight  in  WEIGHT_W  signed log-rate weight.
- run_req  in  1  one-cycle request for a detection pass.
- adj_we  out  1  adjacency write strobe.
- adj_row, adj_col  out  VID_W each  write address.
- adj_data  out  WEIGHT_W  write data.
- mem_sel  out  2  memory owner: 0 engine, 1 Bellman, 2 cycle detect.
- bellman_start  out  1  one-cycle start pulse.
- bellman_done  in  1  Bellman pass finished.
- cycle_start  out  1  one-cycle start pulse.
- cycle_done  in  1  cycle detect finished.
- cycle_found  in  1  qualified by cycle_done.
- busy  out  1  state ≠ IDLE or FIFO non-empty.
- result_valid  out  1  one-cycle pulse at pass end.
- result_cycle  out  1  last pass found a cycle; held until the next result.
- pass_count  out  16  completed passes, wraps.
- err_self_loop  out  1  sticky: an update had src == dst.

## Operation
- States: IDLE, DRAIN_FWD, DRAIN_REV, START_BF, WAIT_BF, START_CD, WAIT_CD, REPORT.
- **Accepting updates:** an update is accepted when upd_valid && upd_ready. Accepted updates enter the FIFO in order.
- **run_req:** sets a pending flag. Multiple requests before service merge into one pass. A request that arrives during a pass is kept pending and is served afterwards.
- **IDLE:**
  - FIFO non-empty → DRAIN_FWD.
  - Else, pending set → START_BF, and pending is cleared.
  - The drain always takes priority: queued updates are applied before any pass starts.
- **DRAIN_FWD:** writes adj[src][dst] = w with adj_we = 1.
  - If the entry has src == dst: nothing is written, err_self_loop is set, and the entry is popped.
  - Next state is DRAIN_REV, or pop-and-return per the Configuration section.
- **DRAIN_REV:** writes adj[dst][src] = −w, then pops the entry.
  - Next state is DRAIN_FWD if the FIFO is still non-empty.
  - Otherwise IDLE, with pending forced to 1 if AUTO_RUN = 1.
- **Negation:** two's complement at WEIGHT_W bits. The most negative value saturates to the maximum positive value.
- **START_BF:** bellman_start = 1 for one cycle, mem_sel = 1 → WAIT_BF.
- **WAIT_BF:** mem_sel = 1; on bellman_done → START_CD. bellman_done is ignored in every other state.
- **START_CD:** cycle_start = 1, mem_sel = 2 → WAIT_CD.
- **WAIT_CD:** mem_sel = 2; on cycle_done, latch cycle_found → REPORT.
- **REPORT:** result_valid = 1, result_cycle updated, pass_count += 1 → IDLE.
- The FIFO keeps accepting updates during a pass. They are not written until the engine returns to IDLE.

## Timing
- Reset values:
  - State IDLE, FIFO empty, pending = 0.
  - All outputs 0, except upd_ready = 0 while engine_reset is high and 1 from the first clk after release.
- Reset mid-operation: the FIFO is flushed, any pending request is lost, and start pulses drop immediately. The sub-blocks are reset separately.
- upd_ready = !full, derived from the registered count. A push and a pop in the same cycle leave the count unchanged.
- Update accepted at cycle t while IDLE with an empty FIFO:
  - forward write at t+1;
  - reverse write at t+2;
  - back in IDLE at t+3.
- run_req at t while IDLE with an empty FIFO: bellman_start at t+1.
- bellman_done at t: cycle_start at t+1.
- cycle_done at t: result_valid at t+1.
- adj_* are combinational from state and the FIFO head. They are zero whenever adj_we = 0.

## Configuration
- REVERSE_EDGE_EN defined: each update costs 2 cycles (FWD, REV), and the negated reverse edge is written.
- REVERSE_EDGE_EN undefined:
  - DRAIN_REV is never entered and each update costs 1 cycle.
  - DRAIN_FWD pops the entry and goes to DRAIN_FWD if the FIFO is still non-empty, otherwise IDLE.
  - The AUTO_RUN pending rule moves to DRAIN_FWD.

## Test plan
- **Reset and basic writes (REVERSE_EDGE_EN):** reset, then push (src 2, dst 5, w 0x00000100).
  - Required: adj write (2,5,0x00000100), then (5,2,0xFFFFFF00) on consecutive cycles, then busy = 0.
- **Full FIFO, out of reset:** push 9 updates back-to-back while engine_reset is held high until the first push.
  - Required: upd_ready = 0 during reset. After release, ready deasserts exactly when 8 entries are held, and all entries are written in order.
- **Saturating negation:** w = 0x80000000.
  - Required: reverse write carries 0x7FFFFFFF.
- **Self loop:** src = dst = 3.
  - Required: no adj_we, err_self_loop = 1 until reset.
- **Pass sequencing:** run_req; model bellman_done after 20 cycles and cycle_done with cycle_found = 1 after 10 more.
  - Required: mem_sel goes 1, then 2, then 0. result_valid pulses once, result_cycle = 1, pass_count = 1.
- **Request during a pass:** issue a second run_req plus one update during WAIT_BF.
  - Required: the update is written after REPORT, then a second pass runs, ending with pass_count = 2.
